// File: rtl/arith_logic_pkg.sv
// Shared types for the arith/logic datapath: request/result layouts, sequencer states
// and the small combinational helpers used by the single-cycle operations.
package arith_logic_pkg;

    typedef enum logic [1:0] {ARITH_ADD, ARITH_SUB, ARITH_MUL, ARITH_DIV} arithmetic_op_e;
    typedef enum logic [1:0] {NAND_OP, NOR_OP, NOT_OP, XOR_OP} logical_op_e;

    typedef struct packed {
        arithmetic_op_e arithmetic_op;
        logical_op_e    logical_op;
        logic [7:0]     data1;
        logic [7:0]     data2;
    } arith_logic_info;

    typedef struct packed {
        logic [7:0] remainder;
        logic [7:0] quotient;
    } div_result_t;

    typedef union packed {
        logic [15:0] result;
        div_result_t div;
    } arith_logic_result;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_EXEC, SEQ_ITER, SEQ_DONE} seq_state_e;

    localparam int ITER_CNT   = 8;
    localparam int ITER_CNT_W = 3;

    // 9-bit sum of two zero-extended bytes, widened to the result width.
    function automatic logic [15:0] addition(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return {7'b0, sum};
    endfunction

    function automatic logic [15:0] subtraction(input logic [7:0] a, input logic [7:0] b);
        return {8'b0, a} - {8'b0, b};
    endfunction

    function automatic logic [7:0] logic_eval(input logical_op_e op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [7:0] r;
        case (op)
            NAND_OP: r = ~(a & b);
            NOR_OP:  r = ~(a | b);
            NOT_OP:  r = ~a;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arith_logic_iter_unit.sv
// Eight-step shift-add multiplier / restoring divider. The first step runs in the
// start cycle straight from the inputs, so eight consecutive cycles yield the result.
module arith_logic_iter_unit
    import arith_logic_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_div,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        done,
    output logic [15:0] res
);

    logic [15:0]           acc_q, acc_d;
    logic [ITER_CNT_W-1:0] step_q, step_d;
    logic                  busy_q, busy_d;

    logic                  active;
    logic [ITER_CNT_W-1:0] step_idx;
    logic [15:0]           acc_base;
    logic [15:0]           mul_next;
    logic [8:0]            shifted;
    logic [7:0]            rem_next;
    logic [7:0]            quot_next;

    // a and b are held stable by the sequencer for the whole run, so only the
    // accumulator and step index need to live here.
    always_comb begin
        active   = start || busy_q;
        step_idx = start ? '0 : step_q;
        acc_base = start ? '0 : acc_q;

        mul_next = acc_base + (b[step_idx] ? ({8'b0, a} << step_idx) : 16'h0000);

        shifted = {acc_base[15:8], a[3'd7 - step_idx]};
        if (shifted >= {1'b0, b}) begin
            rem_next  = 8'(shifted - {1'b0, b});
            quot_next = {acc_base[6:0], 1'b1};
        end else begin
            rem_next  = shifted[7:0];
            quot_next = {acc_base[6:0], 1'b0};
        end

        acc_d  = acc_q;
        step_d = '0;
        busy_d = busy_q;
        if (active) begin
            acc_d  = is_div ? {rem_next, quot_next} : mul_next;
            step_d = step_idx + 1'b1;
            busy_d = (step_idx != ITER_CNT_W'(ITER_CNT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    assign done = active && (step_idx == ITER_CNT_W'(ITER_CNT - 1));
    assign res  = acc_d;

endmodule

// File: rtl/arith_logic_sequencer.sv
// One-op-in-flight command sequencer for the arith/logic datapath.
// Optional statistics outputs op_count/div0_count are built with ARITH_LOGIC_SEQ_STATS_EN.
module arith_logic_sequencer
    import arith_logic_pkg::*;
#(
    parameter bit          FAST_MUL = 1'b0,
    parameter logic [15:0] DIV0_VAL = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_logic,
    input  logic [19:0] req_info,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_div0
`ifdef ARITH_LOGIC_SEQ_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  div0_count
`endif
);

    seq_state_e            state_q, state_d;
    arith_logic_info       info_q;
    logic                  is_logic_q;
    logic [15:0]           result_q;
    logic                  div0_q;
    logic [ITER_CNT_W-1:0] cnt_q;

    arith_logic_result     exec_res;
    logic                  exec_div0;
    logic                  needs_iter;
    logic                  iter_start;
    logic                  iter_done;
    logic [15:0]           iter_res;

    // Single-cycle results; mul (slow build) and non-zero div are handed to the iter unit.
    always_comb begin
        exec_res   = '0;
        exec_div0  = 1'b0;
        needs_iter = 1'b0;
        if (is_logic_q) begin
            exec_res.result = {8'h00, logic_eval(info_q.logical_op, info_q.data1, info_q.data2)};
        end else begin
            case (info_q.arithmetic_op)
                ARITH_ADD: exec_res.result = addition(info_q.data1, info_q.data2);
                ARITH_SUB: exec_res.result = subtraction(info_q.data1, info_q.data2);
                ARITH_MUL: begin
                    if (FAST_MUL) exec_res.result = {8'h00, info_q.data1} * {8'h00, info_q.data2};
                    else          needs_iter = 1'b1;
                end
                default: begin
                    if (info_q.data2 == 8'h00) begin
                        exec_res.result = DIV0_VAL;
                        exec_div0       = 1'b1;
                    end else begin
                        needs_iter = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SEQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE: if (req_valid) state_d = SEQ_EXEC;
            SEQ_EXEC: state_d = needs_iter ? SEQ_ITER : SEQ_DONE;
            SEQ_ITER: if (iter_done) state_d = SEQ_DONE;
            SEQ_DONE: if (rsp_ready) state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so it reads 0 for as long as reset is held.
    always_comb begin
        req_ready  = rst_n && (state_q == SEQ_IDLE);
        rsp_valid  = (state_q == SEQ_DONE);
        iter_start = (state_q == SEQ_ITER) && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            info_q     <= '0;
            is_logic_q <= 1'b0;
            result_q   <= '0;
            div0_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (state_q == SEQ_IDLE && req_valid) begin
                info_q     <= arith_logic_info'(req_info);
                is_logic_q <= req_is_logic;
            end
            if (state_q == SEQ_EXEC) begin
                div0_q <= exec_div0;
                if (!needs_iter) result_q <= exec_res.result;
            end
            if (state_q == SEQ_ITER && iter_done) result_q <= iter_res;
            cnt_q <= (state_q == SEQ_ITER) ? cnt_q + 1'b1 : '0;
        end
    end

    arith_logic_iter_unit u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (info_q.arithmetic_op == ARITH_DIV),
        .a      (info_q.data1),
        .b      (info_q.data2),
        .done   (iter_done),
        .res    (iter_res)
    );

    assign rsp_result = result_q;
    assign rsp_div0   = div0_q;

`ifdef ARITH_LOGIC_SEQ_STATS_EN
    logic [15:0] op_count_q;
    logic [7:0]  div0_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q   <= '0;
            div0_count_q <= '0;
        end else if (state_q == SEQ_DONE && rsp_ready) begin
            if (op_count_q != '1) op_count_q <= op_count_q + 1'b1;
            if (div0_q && div0_count_q != '1) div0_count_q <= div0_count_q + 1'b1;
        end
    end

    assign op_count   = op_count_q;
    assign div0_count = div0_count_q;
`endif

endmodule

// File: tb/tb_arith_logic_sequencer.sv
// Self-checking bench: spec-level model plus per-cycle compare, directed vectors with
// literal expectations, and a second instance built with the combinational multiplier.
module tb_arith_logic_sequencer;
    import arith_logic_pkg::*;

    localparam bit MAIN_FAST = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_is_logic, rsp_valid, rsp_ready, rsp_div0;
    logic [19:0] req_info;
    logic [15:0] rsp_result;
    logic        f_req_valid, f_req_ready, f_req_is_logic, f_rsp_valid, f_rsp_ready, f_rsp_div0;
    logic [19:0] f_req_info;
    logic [15:0] f_rsp_result;
`ifdef ARITH_LOGIC_SEQ_STATS_EN
    logic [15:0] op_count, f_op_count;
    logic [7:0]  div0_count, f_div0_count;
`endif

    arith_logic_sequencer #(.FAST_MUL(MAIN_FAST)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_logic(req_is_logic), .req_info(req_info), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_div0(rsp_div0)
`ifdef ARITH_LOGIC_SEQ_STATS_EN
        , .op_count(op_count), .div0_count(div0_count)
`endif
    );

    arith_logic_sequencer #(.FAST_MUL(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_is_logic(f_req_is_logic), .req_info(f_req_info), .rsp_valid(f_rsp_valid),
        .rsp_ready(f_rsp_ready), .rsp_result(f_rsp_result), .rsp_div0(f_rsp_div0)
`ifdef ARITH_LOGIC_SEQ_STATS_EN
        , .op_count(f_op_count), .div0_count(f_div0_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level result: {div0, result}
    function automatic logic [16:0] model_op(input logic is_l, input logic [19:0] info);
        int         a, b, r;
        logic [7:0] la, lb, lr;
        logic       d0;
        a  = int'(info[15:8]);
        b  = int'(info[7:0]);
        la = info[15:8];
        lb = info[7:0];
        d0 = 1'b0;
        r  = 0;
        if (is_l) begin
            case (info[17:16])
                2'd0:    lr = ~(la & lb);
                2'd1:    lr = ~(la | lb);
                2'd2:    lr = ~la;
                default: lr = la ^ lb;
            endcase
            r = int'(lr);
        end else begin
            case (info[19:18])
                2'd0: r = a + b;
                2'd1: r = (a - b + 65536) % 65536;
                2'd2: r = a * b;
                default: begin
                    if (b == 0) begin
                        r  = 16'hFFFF;
                        d0 = 1'b1;
                    end else begin
                        r = (a % b) * 256 + a / b;
                    end
                end
            endcase
        end
        return {d0, r[15:0]};
    endfunction

    function automatic int model_lat(input logic is_l, input logic [19:0] info);
        if (is_l) return 2;
        case (info[19:18])
            2'd2:    return MAIN_FAST ? 2 : 10;
            2'd3:    return (info[7:0] == 8'h00) ? 2 : 10;
            default: return 2;
        endcase
    endfunction

    // Model: cycle index of the accept cycle is 0; rsp_valid rises in cycle lat.
    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_done_edge = 0;
    logic [15:0] m_res = '0;
    logic        m_div0 = 1'b0;
    int          m_ops = 0;
    int          m_div0s = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ops   <= 0;
            m_div0s <= 0;
        end else if (m_busy) begin
            if (cyc + 1 > m_done_edge && rsp_ready) begin
                m_busy  <= 1'b0;
                m_ops   <= m_ops + 1;
                m_div0s <= m_div0s + (m_div0 ? 1 : 0);
            end
        end else if (req_valid) begin
            m_busy                <= 1'b1;
            m_done_edge           <= cyc + 1 + model_lat(req_is_logic, req_info) - 1;
            {m_div0, m_res}       <= model_op(req_is_logic, req_info);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_div0", rsp_div0, 0);
        end else begin
            check("cyc_req_ready", req_ready, !m_busy);
            check("cyc_rsp_valid", rsp_valid, m_busy && (cyc >= m_done_edge));
            if (m_busy && cyc >= m_done_edge) begin
                check("cyc_rsp_result", rsp_result, m_res);
                check("cyc_rsp_div0", rsp_div0, m_div0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One transaction on the main instance with literal expectations.
    task automatic run_op(input string name, input logic is_l, input logic [1:0] aop,
                          input logic [1:0] lop, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res, input logic exp_d0, input int exp_lat,
                          input int hold);
        int k;
        int guard;
        req_is_logic = is_l;
        req_info     = {aop, lop, a, b};
        req_valid    = 1'b1;
        rsp_ready    = 1'b0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s accept: req_ready stayed 0, required 1", name);
            req_valid = 1'b0;
            return;
        end
        tick();
        // keep req_valid high with altered fields; they must be ignored while busy
        req_info     = ~req_info;
        req_is_logic = ~is_l;
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        check({name, "_lat"}, k + 1, exp_lat);
        check({name, "_res"}, rsp_result, exp_res);
        check({name, "_div0"}, rsp_div0, exp_d0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "_hold_valid"}, rsp_valid, 1);
            check({name, "_hold_res"}, rsp_result, exp_res);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check({name, "_ready_after"}, req_ready, 1);
        $display("op %s: result=%h div0=%0d latency=%0d", name, rsp_result, rsp_div0, k + 1);
    endtask

    initial begin
        int k;
        int guard;
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_logic = 1'b0; req_info = '0; rsp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_is_logic = 1'b0; f_req_info = '0; f_rsp_ready = 1'b0;
        repeat (3) tick();
        check("ready_in_reset", req_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", req_ready, 1);

        run_op("add_ff_01", 1'b0, 2'd0, 2'd0, 8'hFF, 8'h01, 16'h0100, 1'b0, 2, 0);
        run_op("sub_3_5",   1'b0, 2'd1, 2'd0, 8'h03, 8'h05, 16'hFFFE, 1'b0, 2, 0);
        run_op("nand",      1'b1, 2'd0, 2'd0, 8'hF0, 8'h3C, 16'h00CF, 1'b0, 2, 0);
        run_op("mul_ff_ff", 1'b0, 2'd2, 2'd0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 10, 0);
        run_op("div_200_7", 1'b0, 2'd3, 2'd0, 8'd200, 8'd7, 16'h041C, 1'b0, 10, 0);
        run_op("div_5_0",   1'b0, 2'd3, 2'd0, 8'd5, 8'd0, 16'hFFFF, 1'b1, 2, 0);
        run_op("div_hold",  1'b0, 2'd3, 2'd0, 8'hFF, 8'h10, 16'h0F0F, 1'b0, 10, 5);
        run_op("nor",       1'b1, 2'd0, 2'd1, 8'h0F, 8'hF0, 16'h0000, 1'b0, 2, 0);
        run_op("not",       1'b1, 2'd0, 2'd2, 8'h5A, 8'hC3, 16'h00A5, 1'b0, 2, 1);
        run_op("xor",       1'b1, 2'd0, 2'd3, 8'hA5, 8'h0F, 16'h00AA, 1'b0, 2, 0);
        run_op("mul_c_d",   1'b0, 2'd2, 2'd0, 8'h0C, 8'h0D, 16'h009C, 1'b0, 10, 0);
        run_op("add_7f_01", 1'b0, 2'd0, 2'd0, 8'h7F, 8'h01, 16'h0080, 1'b0, 2, 0);
        run_op("div_7_200", 1'b0, 2'd3, 2'd0, 8'd7, 8'd200, 16'h0700, 1'b0, 10, 0);
        run_op("div_255_1", 1'b0, 2'd3, 2'd0, 8'd255, 8'd1, 16'h00FF, 1'b0, 10, 2);

        // Abort a divide in its fourth ITER cycle.
        req_is_logic = 1'b0;
        req_info     = {2'd3, 2'd0, 8'd200, 8'd7};
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("abort_not_done", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_result", rsp_result, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("abort_ready_release", req_ready, 1);
        check("abort_valid_release", rsp_valid, 0);
        $display("op abort_div: reset applied mid-iteration");
        run_op("add_after_abort", 1'b0, 2'd0, 2'd0, 8'h12, 8'h34, 16'h0046, 1'b0, 2, 0);

        // Combinational-multiplier instance.
        f_req_info  = {2'd2, 2'd0, 8'hFF, 8'hFF};
        f_req_valid = 1'b1;
        guard = 0;
        while (!f_req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("fast_ready", f_req_ready, 1);
        tick();
        f_req_valid = 1'b0;
        k = 0;
        while (!f_rsp_valid && k < 20) begin
            tick();
            k++;
        end
        check("fast_mul_lat", k + 1, 2);
        check("fast_mul_res", f_rsp_result, 16'hFE01);
        check("fast_mul_div0", f_rsp_div0, 0);
        f_rsp_ready = 1'b1;
        tick();
        f_rsp_ready = 1'b0;
        check("fast_ready_after", f_req_ready, 1);
        $display("op fast_mul_ff_ff: result=%h latency=%0d", f_rsp_result, k + 1);

`ifdef ARITH_LOGIC_SEQ_STATS_EN
        tick();
        check("stats_op_count", op_count, m_ops);
        check("stats_div0_count", div0_count, m_div0s);
        check("stats_op_count_lit", op_count, 1);
        check("stats_fast_op_count", f_op_count, 1);
        check("stats_fast_div0_count", f_div0_count, 0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
